// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared encodings for the SPI transaction sequencer
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WAIT_RDY,
        XFER,
        GAP,
        HOLD
    } state_t;

    localparam int RW_BIT    = 7;
    localparam int BURST_BIT = 6;
    localparam int ADDR_MSB  = 5;

    localparam logic [7:0] RD_DUMMY = 8'h00;

    function automatic logic [7:0] make_header(input logic rw, input logic burst,
                                               input logic [ADDR_MSB:0] addr);
        logic [7:0] h;
        h             = '0;
        h[RW_BIT]     = rw;
        h[BURST_BIT]  = burst;
        h[ADDR_MSB:0] = addr;
        return h;
    endfunction

endpackage

// File: rtl/cycle_counter.sv
// rtl/cycle_counter.sv - loadable down-counter with terminal-count flag
module cycle_counter #(
    parameter int W = 13
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] count;

    // Parks at zero so tc stays asserted until the next load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/spi_txn_ctrl.sv
// rtl/spi_txn_ctrl.sv - turns one register command into a CS-framed SPI transaction
module spi_txn_ctrl
    import spi_pkg::*;
#(
    parameter int TIMEOUT_CYC = 4096,
    parameter int CS_SETUP    = 4,
    parameter int CS_HOLD     = 4,
    parameter int MAX_LEN     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_rw,
    input  logic                       cmd_burst,
    input  logic [5:0]                 cmd_addr,
    input  logic [$clog2(MAX_LEN)-1:0] cmd_len,
    input  logic [7:0]                 wr_data,
    output logic                       wr_req,
    output logic [7:0]                 rd_data,
    output logic                       rd_valid,
    output logic [7:0]                 status,
    output logic                       done,
    output logic                       timeout,
    output logic                       cs_n,
    output logic                       spi_start,
    output logic [7:0]                 spi_data_in,
    input  logic [7:0]                 spi_data_out,
    input  logic                       spi_new_data,
    input  logic                       spi_chip_rdy
);

    localparam int LEN_W   = $clog2(MAX_LEN);
    localparam int MAX_SH  = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int CNT_MAX = (TIMEOUT_CYC > MAX_SH) ? TIMEOUT_CYC : MAX_SH;
    localparam int CW      = $clog2(CNT_MAX + 1);

    state_t             state;
    logic               rw_q;
    logic               hdr_phase;
    logic [7:0]         hdr_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   byte_cnt;
    logic               last_byte;
    logic               cnt_load;
    logic [CW-1:0]      cnt_val;
    logic               cnt_tc;

    assign last_byte = !hdr_phase && (byte_cnt == len_q);

    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = '0;
        case (state)
            IDLE: if (cmd_ready && cmd_valid) begin
                cnt_load = 1'b1;
                cnt_val  = CW'(CS_SETUP - 1);
            end
            SETUP: if (cnt_tc) begin
                cnt_load = 1'b1;
                cnt_val  = CW'(TIMEOUT_CYC - 1);
            end
            XFER: if (spi_new_data && last_byte) begin
                cnt_load = 1'b1;
                cnt_val  = CW'(CS_HOLD - 1);
            end
            default: ;
        endcase
    end

    cycle_counter #(.W(CW)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .tc       (cnt_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cmd_ready   <= 1'b0;
            cs_n        <= 1'b1;
            spi_start   <= 1'b0;
            spi_data_in <= 8'h00;
            rd_data     <= 8'h00;
            rd_valid    <= 1'b0;
            status      <= 8'h00;
            done        <= 1'b0;
            timeout     <= 1'b0;
            wr_req      <= 1'b0;
            rw_q        <= 1'b0;
            hdr_phase   <= 1'b0;
            hdr_q       <= 8'h00;
            len_q       <= '0;
            byte_cnt    <= '0;
        end else begin
            rd_valid <= 1'b0;
            done     <= 1'b0;
            timeout  <= 1'b0;
            wr_req   <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_ready && cmd_valid) begin
                        cmd_ready <= 1'b0;
                        rw_q      <= cmd_rw;
                        hdr_q     <= make_header(cmd_rw, cmd_burst, cmd_addr);
                        len_q     <= cmd_len;
                        byte_cnt  <= '0;
                        hdr_phase <= 1'b1;
                        cs_n      <= 1'b0;
                        state     <= SETUP;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                SETUP: if (cnt_tc) state <= WAIT_RDY;
                WAIT_RDY: begin
                    if (!spi_chip_rdy) begin
                        spi_data_in <= hdr_q;
                        spi_start   <= 1'b1;
                        state       <= XFER;
                    end else if (cnt_tc) begin
                        timeout <= 1'b1;
                        done    <= 1'b1;
                        cs_n    <= 1'b1;
                        state   <= IDLE;
                    end
                end
                XFER: if (spi_new_data) begin
                    spi_start <= 1'b0;
                    if (hdr_phase) begin
                        status    <= spi_data_out;
                        hdr_phase <= 1'b0;
                        wr_req    <= !rw_q;
                        state     <= GAP;
                    end else begin
                        if (rw_q) begin
                            rd_data  <= spi_data_out;
                            rd_valid <= 1'b1;
                        end
                        // Compare before incrementing so len=15 never wraps the counter.
                        if (last_byte) begin
                            state <= HOLD;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                            wr_req   <= !rw_q;
                            state    <= GAP;
                        end
                    end
                end
                GAP: begin
                    spi_data_in <= rw_q ? RD_DUMMY : wr_data;
                    spi_start   <= 1'b1;
                    state       <= XFER;
                end
                HOLD: if (cnt_tc) begin
                    cs_n  <= 1'b1;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_txn_ctrl.sv
// tb/tb_spi_txn_ctrl.sv - scoreboard bench for spi_txn_ctrl
module tb_spi_txn_ctrl;

    localparam int TIMEOUT_CYC = 16;
    localparam int CS_SETUP    = 4;
    localparam int CS_HOLD     = 4;
    localparam int MAX_LEN     = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_rw = 1'b0;
    logic       cmd_burst = 1'b0;
    logic [5:0] cmd_addr = 6'h00;
    logic [3:0] cmd_len = 4'h0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_req;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [7:0] status;
    logic       done;
    logic       timeout;
    logic       cs_n;
    logic       spi_start;
    logic [7:0] spi_data_in;
    logic [7:0] spi_data_out = 8'h00;
    logic       spi_new_data = 1'b0;
    logic       spi_chip_rdy = 1'b1;

    always #5 clk = ~clk;

    spi_txn_ctrl #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CS_SETUP    (CS_SETUP),
        .CS_HOLD     (CS_HOLD),
        .MAX_LEN     (MAX_LEN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_rw       (cmd_rw),
        .cmd_burst    (cmd_burst),
        .cmd_addr     (cmd_addr),
        .cmd_len      (cmd_len),
        .wr_data      (wr_data),
        .wr_req       (wr_req),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .status       (status),
        .done         (done),
        .timeout      (timeout),
        .cs_n         (cs_n),
        .spi_start    (spi_start),
        .spi_data_in  (spi_data_in),
        .spi_data_out (spi_data_out),
        .spi_new_data (spi_new_data),
        .spi_chip_rdy (spi_chip_rdy)
    );

    typedef struct {
        logic       to;
        logic [7:0] st;
    } done_t;

    logic [7:0] exp_mosi[$];
    logic [7:0] exp_rd[$];
    logic [7:0] resp_q[$];
    logic [7:0] wr_q[$];
    done_t      exp_done[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int nd_cnt = 0;
    int rd_cnt = 0;
    int nd_age = 0;
    int cs_low = 0;
    int last_done_cyc = -1;
    int rdy_delay = 3;
    int rdy_cnt = 0;
    logic prev_start = 1'b0;
    logic prev_cs_n = 1'b1;
    logic prev_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        checks++;
        failures++;
        $display("FAIL %s actual=%0h required=no output", name, act);
    endtask

    // Slave model standing in for spi_master: fixed 3-cycle byte time.
    initial begin
        forever begin
            @(negedge clk);
            if (spi_start) begin
                repeat (2) @(negedge clk);
                spi_data_out = (resp_q.size() != 0) ? resp_q.pop_front() : 8'h00;
                spi_new_data = 1'b1;
                @(negedge clk);
                spi_new_data = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (cs_n) begin
            rdy_cnt      = 0;
            spi_chip_rdy = 1'b1;
        end else begin
            rdy_cnt++;
            if (rdy_cnt > rdy_delay) spi_chip_rdy = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (wr_req) begin
            wr_cnt++;
            wr_data = (wr_q.size() != 0) ? wr_q.pop_front() : 8'h00;
        end
    end

    always @(negedge clk) begin
        done_t d;
        #1;
        cyc++;
        if (spi_new_data) begin
            nd_cnt++;
            nd_age = 0;
        end else begin
            nd_age++;
        end
        if (!cs_n) cs_low = prev_cs_n ? 1 : cs_low + 1;
        if (!cs_n && prev_cs_n && last_done_cyc >= 0)
            check("cs_fall_after_idle", 32'((cyc - last_done_cyc) >= 2), 32'd1);
        if (cs_n && !prev_cs_n) check("cs_rise_without_start", 32'(spi_start), 32'd0);
        if (spi_start && !prev_start) begin
            if (exp_mosi.size() == 0) unexpected("mosi_unexpected", 32'(spi_data_in));
            else check("mosi", 32'(spi_data_in), 32'(exp_mosi.pop_front()));
        end
        if (rd_valid) begin
            rd_cnt++;
            if (exp_rd.size() == 0) unexpected("rd_unexpected", 32'(rd_data));
            else check("rd_data", 32'(rd_data), 32'(exp_rd.pop_front()));
        end
        if (done) begin
            if (exp_done.size() == 0) begin
                unexpected("done_unexpected", 32'(timeout));
            end else begin
                d = exp_done.pop_front();
                check("timeout_flag", 32'(timeout), 32'(d.to));
                check("status", 32'(status), 32'(d.st));
                // cs_low/nd_age include the cycle of the triggering event itself
                if (d.to) check("timeout_latency", 32'(cs_low), 32'(CS_SETUP + TIMEOUT_CYC));
                else      check("cs_hold", 32'(nd_age), 32'(CS_HOLD + 1));
            end
            check("cs_n_at_done", 32'(cs_n), 32'd1);
            check("cmd_ready_in_done", 32'(cmd_ready), 32'd0);
            last_done_cyc = cyc;
        end else if (timeout) begin
            unexpected("timeout_without_done", 32'(timeout));
        end
        if (prev_done) check("cmd_ready_after_done", 32'(cmd_ready), 32'd1);
        prev_start = spi_start;
        prev_cs_n  = cs_n;
        prev_done  = done;
    end

    task automatic send(input logic rw, input logic burst, input logic [5:0] addr,
                        input logic [3:0] len);
        cmd_rw    = rw;
        cmd_burst = burst;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_valid = 1'b1;
        for (int i = 0; i < 300 && !cmd_ready; i++) @(negedge clk);
        if (!cmd_ready) unexpected("cmd_accept_timeout", 32'(cmd_ready));
        @(negedge clk);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 600 && exp_done.size() != 0; i++) @(negedge clk);
        if (exp_done.size() != 0) unexpected("done_wait_timeout", 32'(exp_done.size()));
        repeat (2) @(negedge clk);
    endtask

    int wr0, nd0, rd0;

    initial begin
        #400000;
        $display("FAIL global_watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_cs_n", 32'(cs_n), 32'd1);
        check("rst_spi_start", 32'(spi_start), 32'd0);
        check("rst_spi_data_in", 32'(spi_data_in), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_status", 32'(status), 32'd0);
        check("rst_pulses", 32'({done, timeout, rd_valid, wr_req}), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        // 1: single write
        wr0 = wr_cnt; nd0 = nd_cnt;
        rdy_delay = 3;
        exp_mosi.push_back(8'h0A); exp_mosi.push_back(8'h5C);
        wr_q.push_back(8'h5C);
        resp_q.push_back(8'h80); resp_q.push_back(8'hEE);
        exp_done.push_back('{1'b0, 8'h80});
        send(1'b0, 1'b0, 6'h0A, 4'd0);
        cmd_valid = 1'b0;
        wait_idle();
        check("t1_wr_req_count", 32'(wr_cnt - wr0), 32'd1);
        check("t1_new_data_count", 32'(nd_cnt - nd0), 32'd2);

        // 2: burst read, chip becomes ready while already waiting
        wr0 = wr_cnt; rd0 = rd_cnt;
        rdy_delay = 8;
        exp_mosi.push_back(8'hFF);
        for (int i = 0; i < 4; i++) exp_mosi.push_back(8'h00);
        resp_q.push_back(8'h0F);
        resp_q.push_back(8'h11); resp_q.push_back(8'h22);
        resp_q.push_back(8'h33); resp_q.push_back(8'h44);
        exp_rd.push_back(8'h11); exp_rd.push_back(8'h22);
        exp_rd.push_back(8'h33); exp_rd.push_back(8'h44);
        exp_done.push_back('{1'b0, 8'h0F});
        send(1'b1, 1'b1, 6'h3F, 4'd3);
        cmd_valid = 1'b0;
        wait_idle();
        check("t2_rd_valid_count", 32'(rd_cnt - rd0), 32'd4);
        check("t2_wr_req_count", 32'(wr_cnt - wr0), 32'd0);

        // 3: chip never ready; status keeps the previous value
        nd0 = nd_cnt;
        rdy_delay = 100000;
        exp_done.push_back('{1'b1, 8'h0F});
        send(1'b0, 1'b0, 6'h05, 4'd0);
        cmd_valid = 1'b0;
        wait_idle();
        check("t3_no_new_data", 32'(nd_cnt - nd0), 32'd0);
        rdy_delay = 3;

        // 4: maximum length write
        wr0 = wr_cnt; nd0 = nd_cnt;
        exp_mosi.push_back(8'h12);
        resp_q.push_back(8'h3C);
        for (int i = 0; i < 16; i++) begin
            exp_mosi.push_back(8'hA0 ^ 8'(i));
            wr_q.push_back(8'hA0 ^ 8'(i));
            resp_q.push_back(8'h00);
        end
        exp_done.push_back('{1'b0, 8'h3C});
        send(1'b0, 1'b0, 6'h12, 4'd15);
        cmd_valid = 1'b0;
        wait_idle();
        check("t4_wr_req_count", 32'(wr_cnt - wr0), 32'd16);
        check("t4_new_data_count", 32'(nd_cnt - nd0), 32'd17);

        // 5: reset during the third data byte
        wr0 = wr_cnt;
        exp_mosi.push_back(8'h21);
        for (int i = 1; i <= 4; i++) begin
            exp_mosi.push_back(8'(i));
            wr_q.push_back(8'(i));
        end
        for (int i = 0; i < 5; i++) resp_q.push_back(8'h00);
        exp_done.push_back('{1'b0, 8'h00});
        send(1'b0, 1'b0, 6'h21, 4'd3);
        cmd_valid = 1'b0;
        for (int i = 0; i < 300 && (wr_cnt - wr0) < 3; i++) @(negedge clk);
        check("t5_reached_third_byte", 32'(wr_cnt - wr0), 32'd3);
        @(negedge clk);
        check("t5_pre_reset_cs_n", 32'(cs_n), 32'd0);
        check("t5_pre_reset_start", 32'(spi_start), 32'd1);
        rst = 1'b0;
        #1;
        check("t5_async_cs_n", 32'(cs_n), 32'd1);
        check("t5_async_start", 32'(spi_start), 32'd0);
        repeat (6) @(negedge clk);
        exp_mosi.delete(); exp_rd.delete(); exp_done.delete();
        resp_q.delete(); wr_q.delete();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        exp_mosi.push_back(8'h15); exp_mosi.push_back(8'hC3);
        wr_q.push_back(8'hC3);
        resp_q.push_back(8'h42); resp_q.push_back(8'h00);
        exp_done.push_back('{1'b0, 8'h42});
        send(1'b0, 1'b0, 6'h15, 4'd0);
        cmd_valid = 1'b0;
        wait_idle();

        // 6: back-to-back with cmd_valid held high
        rd0 = rd_cnt;
        exp_mosi.push_back(8'h01); exp_mosi.push_back(8'hAA); exp_mosi.push_back(8'hBB);
        wr_q.push_back(8'hAA); wr_q.push_back(8'hBB);
        resp_q.push_back(8'h55); resp_q.push_back(8'h00); resp_q.push_back(8'h00);
        exp_done.push_back('{1'b0, 8'h55});
        exp_mosi.push_back(8'h82); exp_mosi.push_back(8'h00);
        resp_q.push_back(8'h07); resp_q.push_back(8'h99);
        exp_rd.push_back(8'h99);
        exp_done.push_back('{1'b0, 8'h07});
        send(1'b0, 1'b0, 6'h01, 4'd1);
        send(1'b1, 1'b0, 6'h02, 4'd0);
        cmd_valid = 1'b0;
        wait_idle();
        check("t6_rd_valid_count", 32'(rd_cnt - rd0), 32'd1);
        check("t6_mosi_drained", 32'(exp_mosi.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_txn_ctrl.md
Name: spi_txn_ctrl

Overview:
Transaction sequencer that sits between the avionics command logic and spi_master. It turns one register-access command into a complete chip-select-framed SPI transaction:
- waits for the radio's chip-ready (MISO low) after CS assertion,
- sends the header byte, then 1..16 data bytes,
- captures the status byte and the read data.
It owns cs_n and is the only driver of spi_master's start/data_in.

Parameters:
TIMEOUT_CYC, 4096, clk cycles allowed for chip-ready after CS assert before aborting
CS_SETUP, 4, clk cycles between cs_n falling and first start (minimum 1)
CS_HOLD, 4, clk cycles between the last byte's new_data and cs_n rising (minimum 1)
MAX_LEN, 16, maximum data bytes per transaction

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  controller can accept a command (high only in IDLE)
cmd_rw  in  1  1=read, 0=write
cmd_burst  in  1  burst-access flag
cmd_addr  in  6  register address
cmd_len  in  4  data byte count minus 1 (0 -> 1 byte, 15 -> 16 bytes)
wr_data  in  8  write byte for the current data slot
wr_req  out  1  one-cycle pulse: wr_data is sampled this cycle
rd_data  out  8  received data byte
rd_valid  out  1  one-cycle pulse per received data byte
status  out  8  chip status byte, clocked in during the header
done  out  1  one-cycle pulse at transaction end
timeout  out  1  one-cycle pulse on chip-ready abort (coincides with done)
cs_n  out  1  chip select to the radio, active low
spi_start  out  1  to spi_master start
spi_data_in  out  8  to spi_master data_in
spi_data_out  in  8  from spi_master data_out
spi_new_data  in  1  from spi_master new_data
spi_chip_rdy  in  1  from spi_master chip_rdy (high = chip not ready)

Behaviour:
- Reset values: cs_n=1, spi_start=0, spi_data_in=0, cmd_ready=0 for the reset cycle then 1 in IDLE, rd_data=0, status=0, all pulses 0. Reset mid-transaction returns to IDLE with cs_n=1 immediately (asynchronous).
- Header byte = {cmd_rw, cmd_burst, cmd_addr}.
- FSM states: IDLE, SETUP, WAIT_RDY, XFER, GAP, HOLD.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch rw, header, len; drive cs_n=0; go to SETUP.
- SETUP: count CS_SETUP cycles, then go to WAIT_RDY.
- WAIT_RDY:
  - When spi_chip_rdy=0: load the header into spi_data_in, assert spi_start, go to XFER.
  - If the counter reaches TIMEOUT_CYC first: pulse timeout and done together, cs_n=1, go to IDLE. No data pulses are issued on this path.
- XFER:
  - Hold spi_start=1 and spi_data_in stable until spi_new_data.
  - On spi_new_data, clear spi_start.
  - Byte 0 (header): spi_data_out goes to status.
  - Data bytes when rw=1: spi_data_out goes to rd_data, with a rd_valid pulse in the same cycle.
  - If more bytes remain, go to GAP; otherwise go to HOLD.
- GAP:
  - Exactly one cycle with spi_start=0.
  - Next byte = wr_data when rw=0, 8'h00 when rw=1. wr_req pulses in the GAP cycle, and spi_data_in loads the next byte.
  - Return to XFER with spi_start=1.
- wr_req for the first data byte fires in the GAP cycle after the header.
- A transaction sends exactly len+1 data bytes. Byte counter is 4 bits; it must not wrap (len=15 gives 16 bytes).
- HOLD: count CS_HOLD cycles, then cs_n=1, pulse done, go to IDLE. cmd_ready rises in the cycle after done.
- If cmd_valid is asserted during done, it is not accepted until cmd_ready=1.
- spi_new_data outside XFER is ignored.
- cs_n never rises while spi_start=1.

Decomposition:
- Shared package spi_pkg:
  - state encodings;
  - header bit positions (RW_BIT=7, BURST_BIT=6, ADDR_MSB=5);
  - read dummy byte 8'h00.
- One sub-module, cycle_counter: loadable down-counter reused for SETUP, HOLD and the timeout, with a terminal-count output.

Test Plan:
1. Single write: addr=6'h0A, rw=0, len=0, wr_data=8'h5C, chip-ready low after 3 cycles -> MOSI carries 8'h0A then 8'h5C; one wr_req; done pulses once; cs_n high CS_HOLD cycles after the last new_data.
2. Burst read: addr=6'h3F, rw=1, burst=1, len=3, slave returns status 8'h0F then 8'h11,22,33,44 -> header 8'hFF; status=8'h0F; exactly four rd_valid pulses carrying 11,22,33,44; MOSI data bytes are 00.
3. Timeout: MISO held high with TIMEOUT_CYC=16 -> timeout and done pulse together 16 cycles after SETUP; spi_start never asserts; cs_n returns to 1; cmd_ready=1 on the next cycle.
4. Max length: len=15 write -> 16 wr_req pulses and 17 new_data cycles, then done; no counter wrap.
5. Reset mid-transfer: rst low during the third data byte -> cs_n=1, spi_start=0 immediately; after release a new single write completes normally.
6. Back-to-back: cmd_valid held high for two commands -> second cs_n falling edge no earlier than one IDLE cycle after the first done.
